// File: rtl/div_seq.sv
// Sequential restoring divider: unsigned WIDTH-bit quotient and remainder, with divide-by-zero detection.
// Latency: ready pulses WIDTH+1 cycles after the start cycle, or 1 cycle after it for a zero divisor.
// Backpressure: none. A start during CALC is dropped; a start in IDLE or DONE (the ready cycle) is accepted.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] qreg, rreg, breg;
  logic [CW-1:0]    cnt;
  logic             busy_q, ready_q, dz_q;

  logic             accept;
  logic             divisor_zero;
  logic             q_load;
  logic             last_iter;
  logic [WIDTH:0]   t;
  logic [WIDTH:0]   d;

  assign divisor_zero = (divisor == '0);
  assign last_iter    = (cnt == CW'(WIDTH - 1));

  // Shift the quotient MSB into the remainder and trial-subtract the divisor.
  // One extra bit keeps R[WIDTH-1] so divisors with the MSB set divide correctly.
  assign t = {rreg, qreg[WIDTH-1]};
  assign d = t - {1'b0, breg};

  // Next-state and accept decode; a start is only taken outside CALC.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    q_load    = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (start) begin
          accept    = 1'b1;
          q_load    = !divisor_zero;
          state_nxt = divisor_zero ? DONE : CALC;
        end
      end
      CALC: begin
        if (last_iter) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset discards any in-flight request.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Datapath registers: load on accept, otherwise one restoring iteration per CALC cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      qreg    <= '0;
      rreg    <= '0;
      breg    <= '0;
      cnt     <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      ready_q <= (state_nxt == DONE);
      if (accept) begin
        if (q_load) begin
          qreg   <= dividend;
          rreg   <= '0;
          breg   <= divisor;
          cnt    <= '0;
          dz_q   <= 1'b0;
          busy_q <= 1'b1;
        end else begin
          qreg   <= '1;
          rreg   <= dividend;
          dz_q   <= 1'b1;
          busy_q <= 1'b0;
        end
      end else if (state == CALC) begin
        if (!d[WIDTH]) begin
          rreg <= d[WIDTH-1:0];
          qreg <= {qreg[WIDTH-2:0], 1'b1};
        end else begin
          rreg <= t[WIDTH-1:0];
          qreg <= {qreg[WIDTH-2:0], 1'b0};
        end
        // Counter stops at WIDTH-1; the FSM leaves CALC on that edge.
        if (!last_iter) cnt <= cnt + 1'b1;
        if (last_iter) busy_q <= 1'b0;
      end
    end
  end

  assign busy     = busy_q;
  assign ready    = ready_q;
  assign q        = qreg;
  assign r        = rreg;
  assign div_zero = dz_q;

endmodule
